// File: rtl/seg_scan_if.sv
// Segment/anode bundle between the value decoder and the scan driver.
interface seg_scan_if;
  logic [7:0] seven_seg_1;
  logic [7:0] seven_seg_2;
  logic [7:0] seven_seg_3;
  logic [7:0] seven_seg_4;
  logic [1:0] dim;
  logic [3:0] blink_mask;
  logic [7:0] seg_out;
  logic [3:0] an;
  logic       frame_start;

  modport master (
    output seven_seg_1, seven_seg_2, seven_seg_3, seven_seg_4, dim, blink_mask,
    input  seg_out, an, frame_start
  );

  modport slave (
    input  seven_seg_1, seven_seg_2, seven_seg_3, seven_seg_4, dim, blink_mask,
    output seg_out, an, frame_start
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 4-digit common-anode seven-segment driver with per-frame
// snapshot, anti-ghost blanking, 4-level brightness PWM and per-digit blink.
//
// state | meaning
// DIG0  | scanning digit 0 (rightmost); frame snapshot at cnt=0
// DIG1  | scanning digit 1
// DIG2  | scanning digit 2
// DIG3  | scanning digit 3 (leftmost); wrap ends the frame
module seg_scan_driver #(
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int BLINK_FRAMES = 125
) (
  input logic        clk,
  input logic        rstn,
  seg_scan_if.slave  bus
);

  localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
  localparam logic [FW-1:0] FCNT_LAST = FW'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {DIG0 = 2'd0, DIG1 = 2'd1, DIG2 = 2'd2, DIG3 = 2'd3} digit_t;

  digit_t          d;
  logic [1:0]      d_idx;
  logic [CW-1:0]   cnt;
  logic [FW-1:0]   fcnt;
  logic            blink_phase;
  logic [7:0]      shadow [4];
  logic [3:0]      shadow_mask;
  logic [7:0]      seg_q;
  logic [3:0]      an_q;
  logic            fs_q;

  logic [CW-1:0]   off;
  logic [1:0]      p;
  logic            drive;
  logic            snap;
  logic [3:0]      an_nxt;
  logic [7:0]      seg_nxt;

  assign d_idx = d;
  assign snap  = (d == DIG0) && (cnt == '0);

  // PWM phase counts from the start of the lit window, not from the slot.
  always_comb begin
    off     = cnt - BLANK_END;
    p       = off[1:0];
    drive   = (cnt >= BLANK_END) && (p <= bus.dim) &&
              !(shadow_mask[d_idx] && blink_phase);
    an_nxt  = 4'b1111;
    seg_nxt = 8'hFF;
    if (drive) begin
      an_nxt  = ~(4'b0001 << d_idx);
      seg_nxt = shadow[d_idx];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      d           <= DIG0;
      cnt         <= '0;
      fcnt        <= '0;
      blink_phase <= 1'b0;
      for (int i = 0; i < 4; i++) shadow[i] <= 8'hFF;
      shadow_mask <= 4'b0000;
      seg_q       <= 8'hFF;
      an_q        <= 4'b1111;
      fs_q        <= 1'b0;
    end else begin
      seg_q <= seg_nxt;
      an_q  <= an_nxt;
      fs_q  <= snap;
      if (snap) begin
        shadow[0]   <= bus.seven_seg_1;
        shadow[1]   <= bus.seven_seg_2;
        shadow[2]   <= bus.seven_seg_3;
        shadow[3]   <= bus.seven_seg_4;
        shadow_mask <= bus.blink_mask;
      end
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        d   <= digit_t'(d_idx + 2'd1);
        if (d == DIG3) begin
          if (fcnt == FCNT_LAST) begin
            fcnt        <= '0;
            blink_phase <= ~blink_phase;
          end else begin
            fcnt <= fcnt + 1'b1;
          end
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign bus.seg_out     = seg_q;
  assign bus.an          = an_q;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with small geometry (8/2/2).
module tb_seg_scan_driver;
  localparam int DC = 8;
  localparam int BC = 2;
  localparam int BF = 2;
  localparam int FRAME = 4 * DC;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  seg_scan_if bus ();

  seg_scan_driver #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BC), .BLINK_FRAMES(BF)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc;
  int last_fs;
  int hits;
  logic [3:0] tgt_an;
  logic [7:0] tgt_seg;
  logic [7:0] sh [4];
  logic [3:0] shm;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: predict from the state the DUT will see at the coming edge,
  // then compare the registered outputs on the following falling edge.
  task automatic step();
    int c, dd, fr;
    logic ph, drv;
    logic [1:0] dm, p;
    logic [3:0] ea;
    logic [7:0] es;
    if (cyc % FRAME == 0) begin
      sh[0] = bus.seven_seg_1;
      sh[1] = bus.seven_seg_2;
      sh[2] = bus.seven_seg_3;
      sh[3] = bus.seven_seg_4;
      shm   = bus.blink_mask;
    end
    c  = cyc % DC;
    dd = (cyc / DC) % 4;
    fr = cyc / FRAME;
    ph = ((fr / BF) % 2) == 1;
    dm = bus.dim;
    p  = 2'((c - BC) % 4);
    drv = (c >= BC) && (p <= dm) && !(shm[dd] && ph);
    ea = drv ? ~(4'b0001 << dd) : 4'b1111;
    es = drv ? sh[dd] : 8'hFF;
    @(posedge clk);
    @(negedge clk);
    check("an", bus.an, ea);
    check("seg", bus.seg_out, es);
    check("frame_start", bus.frame_start, (c == 0 && dd == 0));
    check("one_anode", ($countones(~bus.an) <= 1), 1);
    if (bus.an == 4'b1111) check("seg_dark", bus.seg_out, 8'hFF);
    if (bus.frame_start) begin
      if (last_fs >= 0) check("fs_period", cyc - last_fs, FRAME);
      last_fs = cyc;
    end
    if (bus.an == tgt_an && bus.seg_out == tgt_seg) hits++;
    cyc++;
  endtask

  task automatic run_frame();
    hits = 0;
    repeat (FRAME) step();
  endtask

  int blink_exp [4] = '{6, 0, 0, 6};

  initial begin
    bus.seven_seg_1 = 8'hC0;
    bus.seven_seg_2 = 8'hF9;
    bus.seven_seg_3 = 8'hA4;
    bus.seven_seg_4 = 8'hB0;
    bus.dim = 2'd3;
    bus.blink_mask = 4'b0000;
    tgt_an = 4'b1110;
    tgt_seg = 8'hC0;
    cyc = 0;
    last_fs = -1;
    repeat (3) @(negedge clk);
    check("rst_an", bus.an, 4'b1111);
    check("rst_seg", bus.seg_out, 8'hFF);
    check("rst_fs", bus.frame_start, 0);
    rstn = 1'b1;

    // basic scan, full brightness
    run_frame();
    check("t1_digit0_hits", hits, 6);
    run_frame();

    // dim=0: only p=0 of each 4-cycle group lit
    bus.seven_seg_1 = 8'h80;
    bus.dim = 2'd0;
    tgt_an = 4'b1110;
    tgt_seg = 8'h80;
    run_frame();
    check("t2_dim0_hits", hits, 2);

    // mid-frame change to digit 2 must wait for the next snapshot
    bus.seven_seg_1 = 8'hC0;
    bus.dim = 2'd3;
    tgt_an = 4'b1011;
    tgt_seg = 8'hA4;
    hits = 0;
    repeat (12) step();
    bus.seven_seg_3 = 8'h99;
    repeat (FRAME - 12) step();
    check("t3_old_value", hits, 6);
    tgt_seg = 8'h99;
    run_frame();
    check("t3_new_value", hits, 6);

    // blink digit 0: frames 5..8 see blink phase 0,1,1,0
    bus.blink_mask = 4'b0001;
    tgt_an = 4'b1110;
    tgt_seg = 8'hC0;
    for (int f = 0; f < 4; f++) begin
      run_frame();
      check("t4_blink_hits", hits, blink_exp[f]);
    end

    // async reset mid-slot on digit 2
    bus.blink_mask = 4'b0000;
    repeat (2 * DC + 6) step();
    check("t5_pre_an", bus.an, 4'b1011);
    #2 rstn = 1'b0;
    #1;
    check("t5_async_an", bus.an, 4'b1111);
    check("t5_async_seg", bus.seg_out, 8'hFF);
    check("t5_async_fs", bus.frame_start, 0);
    @(negedge clk);
    bus.seven_seg_1 = 8'h12;
    bus.seven_seg_2 = 8'h34;
    bus.seven_seg_3 = 8'h56;
    bus.seven_seg_4 = 8'h78;
    @(negedge clk);
    rstn = 1'b1;
    cyc = 0;
    last_fs = -1;
    tgt_an = 4'b1110;
    tgt_seg = 8'h12;
    run_frame();
    check("t5_restart_hits", hits, 6);

    // random inputs, including mid-frame disturbances
    for (int f = 0; f < 10; f++) begin
      for (int i = 0; i < FRAME; i++) begin
        if (i == 0 || $urandom_range(0, 3) == 0) begin
          bus.seven_seg_1 = 8'($urandom);
          bus.seven_seg_2 = 8'($urandom);
          bus.seven_seg_3 = 8'($urandom);
          bus.seven_seg_4 = 8'($urandom);
          bus.dim = 2'($urandom);
          bus.blink_mask = 4'($urandom);
        end
        step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
